// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - pipeline stage register with valid/ready handshake, flush, optional skid entry and stall counter
module wb_pipe_stage #(
    parameter int                WIDTH     = 101,
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    // ST_TWO is only reachable with SKID!=0: in single-entry mode in_ready
    // is low whenever the stage is full and downstream is not draining it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               xfer_in;
    logic               xfer_out;

    // With a skid entry in_ready comes only from the state flops; without
    // one it looks through to out_ready so a full stage can still stream.
    assign in_ready  = (SKID != 0) ? (state_q != ST_TWO)
                                   : (out_ready || (state_q == ST_EMPTY));
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    // Next-state and payload steering; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end else if (xfer_in) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end
                end
                ST_TWO: begin
                    if (xfer_out) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset drops every held entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Count stalled cycles, sticking at all-ones; flush leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - directed and soak checks of wb_pipe_stage in single, skid and narrow-counter builds
module tb_wb_pipe_stage;

    localparam logic [100:0] RV0 = 101'h5A5;
    localparam logic [100:0] RV1 = 101'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          fl  [2];
    logic          iv  [2];
    logic          ir  [2];
    logic          ov  [2];
    logic          orr [2];
    logic [100:0]  id  [2];
    logic [100:0]  od  [2];
    logic [15:0]   sc  [2];

    logic          s_fl, s_iv, s_ir, s_ov, s_or;
    logic [7:0]    s_id, s_od;
    logic [2:0]    s_sc;

    int vectors     = 0;
    int miscompares = 0;

    logic [100:0]  mq   [2][2];
    int            mcnt [2];
    logic [100:0]  last [2];
    logic [15:0]   msc  [2];
    logic          eir, xin, xout;
    logic [100:0]  eod;
    logic [127:0]  r;

    wb_pipe_stage #(.WIDTH(101), .SKID(0), .CNT_W(16), .RESET_VAL(RV0)) u0 (
        .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(orr[0]),
        .stall_cnt(sc[0])
    );

    wb_pipe_stage #(.WIDTH(101), .SKID(1), .CNT_W(16), .RESET_VAL(RV1)) u1 (
        .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(orr[1]),
        .stall_cnt(sc[1])
    );

    wb_pipe_stage #(.WIDTH(8), .SKID(1), .CNT_W(3), .RESET_VAL(8'h00)) us (
        .clk(clk), .reset(reset), .flush(s_fl), .in_valid(s_iv), .in_data(s_id),
        .in_ready(s_ir), .out_valid(s_ov), .out_data(s_od), .out_ready(s_or),
        .stall_cnt(s_sc)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            fl[m] = 1'b0; iv[m] = 1'b0; id[m] = '0; orr[m] = 1'b0;
        end
        s_fl = 1'b0; s_iv = 1'b0; s_id = '0; s_or = 1'b0;
        tick; tick;

        // reset state of all three builds
        chk("rst_u0_valid", 128'(ov[0]), 128'(1'b0));
        chk("rst_u0_data",  128'(od[0]), 128'(RV0));
        chk("rst_u0_cnt",   128'(sc[0]), 128'(0));
        chk("rst_u0_ready", 128'(ir[0]), 128'(1'b1));
        chk("rst_u1_valid", 128'(ov[1]), 128'(1'b0));
        chk("rst_u1_data",  128'(od[1]), 128'(RV1));
        chk("rst_u1_cnt",   128'(sc[1]), 128'(0));
        chk("rst_u1_ready", 128'(ir[1]), 128'(1'b1));
        chk("rst_us_valid", 128'(s_ov),  128'(1'b0));
        chk("rst_us_cnt",   128'(s_sc),  128'(0));
        chk("rst_us_ready", 128'(s_ir),  128'(1'b1));
        reset = 1'b1;

        // streaming 1..8 through the skid build
        orr[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv[1] = 1'b1; id[1] = 101'(i);
            #1;
            chk("stream_ready", 128'(ir[1]), 128'(1'b1));
            tick;
            chk("stream_valid", 128'(ov[1]), 128'(1'b1));
            chk("stream_data",  128'(od[1]), 128'(i));
        end
        iv[1] = 1'b0;
        tick;
        chk("stream_drain_valid", 128'(ov[1]), 128'(1'b0));
        chk("stream_drain_hold",  128'(od[1]), 128'(8));

        // skid fill: A accepted, B absorbed as out_ready drops
        iv[1] = 1'b1; id[1] = 101'hA;
        tick;
        orr[1] = 1'b0; id[1] = 101'hB;
        #1;
        chk("fill_ready_one", 128'(ir[1]), 128'(1'b1));
        tick;
        iv[1] = 1'b0;
        chk("fill_ready_two", 128'(ir[1]), 128'(1'b0));
        chk("fill_valid",     128'(ov[1]), 128'(1'b1));
        chk("fill_head_a",    128'(od[1]), 128'(101'hA));
        chk("fill_cnt",       128'(sc[1]), 128'(1));
        orr[1] = 1'b1;
        tick;
        chk("fill_head_b",    128'(od[1]), 128'(101'hB));
        chk("fill_valid_b",   128'(ov[1]), 128'(1'b1));
        chk("fill_ready_back",128'(ir[1]), 128'(1'b1));
        tick;
        chk("fill_empty",     128'(ov[1]), 128'(1'b0));

        // asynchronous reset while holding two entries
        orr[1] = 1'b0; iv[1] = 1'b1; id[1] = 101'hC;
        tick;
        id[1] = 101'hD;
        tick;
        iv[1] = 1'b0;
        chk("two_ready", 128'(ir[1]), 128'(1'b0));
        chk("two_cnt",   128'(sc[1]), 128'(2));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 128'(ov[1]), 128'(1'b0));
        chk("arst_data",  128'(od[1]), 128'(RV1));
        chk("arst_cnt",   128'(sc[1]), 128'(0));
        chk("arst_ready", 128'(ir[1]), 128'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        iv[1] = 1'b1; id[1] = 101'hE; orr[1] = 1'b1;
        tick;
        chk("post_rst_valid", 128'(ov[1]), 128'(1'b1));
        chk("post_rst_data",  128'(od[1]), 128'(101'hE));

        // flush coinciding with an accepted input
        fl[1] = 1'b1; id[1] = 101'hF;
        tick;
        chk("flush_valid", 128'(ov[1]), 128'(1'b0));
        chk("flush_data",  128'(od[1]), 128'(RV1));
        fl[1] = 1'b0; iv[1] = 1'b0;
        tick;
        chk("flush_lost_valid", 128'(ov[1]), 128'(1'b0));
        chk("flush_lost_data",  128'(od[1]), 128'(RV1));

        // single-entry build stalled for five cycles
        orr[0] = 1'b0; iv[0] = 1'b1; id[0] = 101'h11;
        #1;
        chk("s0_ready_empty", 128'(ir[0]), 128'(1'b1));
        tick;
        chk("s0_valid", 128'(ov[0]), 128'(1'b1));
        chk("s0_data",  128'(od[0]), 128'(101'h11));
        chk("s0_ready_stalled", 128'(ir[0]), 128'(1'b0));
        id[0] = 101'h22;
        repeat (5) tick;
        chk("s0_cnt5",  128'(sc[0]), 128'(5));
        chk("s0_hold",  128'(od[0]), 128'(101'h11));
        orr[0] = 1'b1;
        #1;
        chk("s0_ready_comb", 128'(ir[0]), 128'(1'b1));
        tick;
        chk("s0_next_data",  128'(od[0]), 128'(101'h22));
        chk("s0_next_valid", 128'(ov[0]), 128'(1'b1));
        iv[0] = 1'b0;
        tick;
        chk("s0_drain_valid", 128'(ov[0]), 128'(1'b0));
        chk("s0_drain_hold",  128'(od[0]), 128'(101'h22));
        fl[0] = 1'b1; iv[0] = 1'b1; id[0] = 101'h33;
        tick;
        chk("s0_flush_valid", 128'(ov[0]), 128'(1'b0));
        chk("s0_flush_data",  128'(od[0]), 128'(RV0));
        fl[0] = 1'b0; iv[0] = 1'b0;
        tick;
        chk("s0_flush_lost", 128'(ov[0]), 128'(1'b0));
        chk("s0_flush_cnt",  128'(sc[0]), 128'(5));

        // 3-bit counter saturation
        s_or = 1'b0; s_iv = 1'b1; s_id = 8'h77;
        tick;
        s_iv = 1'b0;
        repeat (3) tick;
        chk("sat_cnt3", 128'(s_sc), 128'(3));
        repeat (7) tick;
        chk("sat_cnt7", 128'(s_sc), 128'(7));
        chk("sat_hold", 128'(s_od), 128'(8'h77));
        s_fl = 1'b1;
        tick;
        chk("sat_flush_cnt",   128'(s_sc), 128'(7));
        chk("sat_flush_valid", 128'(s_ov), 128'(1'b0));
        s_fl = 1'b0;
        tick;
        chk("sat_after_cnt", 128'(s_sc), 128'(7));

        // random soak of both 101-bit builds against a two-entry model
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; msc[m] = '0;
            last[m] = (m == 1) ? RV1 : RV0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                id[m]  = r[100:0];
                iv[m]  = ($urandom_range(0, 9) < 7);
                orr[m] = ($urandom_range(0, 9) < 6);
                fl[m]  = ($urandom_range(0, 99) < 3);
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                eir = (m == 1) ? (mcnt[m] < 2) : (orr[m] || (mcnt[m] == 0));
                eod = (mcnt[m] > 0) ? mq[m][0] : last[m];
                chk("soak_ready", 128'(ir[m]), 128'(eir));
                chk("soak_valid", 128'(ov[m]), 128'(mcnt[m] > 0));
                chk("soak_data",  128'(od[m]), 128'(eod));
                chk("soak_cnt",   128'(sc[m]), 128'(msc[m]));
                if ((mcnt[m] > 0) && !orr[m] && (msc[m] != 16'hFFFF)) msc[m]++;
                if (fl[m]) begin
                    mcnt[m] = 0;
                    last[m] = (m == 1) ? RV1 : RV0;
                end else begin
                    xout = (mcnt[m] > 0) && orr[m];
                    xin  = iv[m] && eir;
                    if (xout) begin
                        last[m]  = mq[m][0];
                        mq[m][0] = mq[m][1];
                        mcnt[m]--;
                    end
                    if (xin) begin
                        mq[m][mcnt[m]] = id[m];
                        mcnt[m]++;
                    end
                end
            end
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
